// File: rtl/bp_be_fe_cmd_gen_if.sv
// ---------------------------------------------------------------------------
// bp_be_fe_cmd_gen_if
// Bundle of every non-clock signal between the backend command generator and
// its environment (backend resolve/trap sources on one side, the frontend PC
// generator redirect/attaboy inputs on the other).
//
//   resolve_*      resolved committed control-flow instruction
//   trap_*         trap / xRET / fence redirect request
//   resume_i       backend wrong-path squash complete
//   redirect_*     single-cycle registered redirect to the frontend
//   attaboy_*      head of the buffered correct-prediction training queue
//   attaboy_yumi_i frontend consumed the queue head
//   drop_cnt_o     saturating count of attaboys dropped on a full queue
//
// modport master : the command generator itself
// modport slave  : the surrounding backend/frontend (or a testbench)
// ---------------------------------------------------------------------------
interface bp_be_fe_cmd_gen_if #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 64
);
    logic                                   resolve_v_i;
    logic [vaddr_width_p-1:0]               resolve_pc_i;
    logic [vaddr_width_p-1:0]               resolve_tgt_i;
    logic [vaddr_width_p-1:0]               resolve_npc_i;
    logic [vaddr_width_p-1:0]               resolve_pred_npc_i;
    logic                                   resolve_br_i;
    logic                                   resolve_jal_i;
    logic                                   resolve_jalr_i;
    logic                                   resolve_taken_i;
    logic [branch_metadata_fwd_width_p-1:0] resolve_metadata_i;
    logic                                   trap_v_i;
    logic [vaddr_width_p-1:0]               trap_npc_i;
    logic                                   resume_i;

    logic                                   redirect_v_o;
    logic                                   redirect_br_v_o;
    logic                                   redirect_br_taken_o;
    logic                                   redirect_br_ntaken_o;
    logic                                   redirect_br_nonbr_o;
    logic [vaddr_width_p-1:0]               redirect_pc_o;
    logic [vaddr_width_p-1:0]               redirect_npc_o;
    logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o;

    logic                                   attaboy_v_o;
    logic                                   attaboy_force_o;
    logic                                   attaboy_taken_o;
    logic                                   attaboy_ntaken_o;
    logic [vaddr_width_p-1:0]               attaboy_pc_o;
    logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o;
    logic                                   attaboy_yumi_i;
    logic [7:0]                             drop_cnt_o;

    modport master (
        input  resolve_v_i, resolve_pc_i, resolve_tgt_i, resolve_npc_i,
               resolve_pred_npc_i, resolve_br_i, resolve_jal_i, resolve_jalr_i,
               resolve_taken_i, resolve_metadata_i, trap_v_i, trap_npc_i,
               resume_i, attaboy_yumi_i,
        output redirect_v_o, redirect_br_v_o, redirect_br_taken_o,
               redirect_br_ntaken_o, redirect_br_nonbr_o, redirect_pc_o,
               redirect_npc_o, redirect_br_metadata_fwd_o,
               attaboy_v_o, attaboy_force_o, attaboy_taken_o, attaboy_ntaken_o,
               attaboy_pc_o, attaboy_br_metadata_fwd_o, drop_cnt_o
    );

    modport slave (
        output resolve_v_i, resolve_pc_i, resolve_tgt_i, resolve_npc_i,
               resolve_pred_npc_i, resolve_br_i, resolve_jal_i, resolve_jalr_i,
               resolve_taken_i, resolve_metadata_i, trap_v_i, trap_npc_i,
               resume_i, attaboy_yumi_i,
        input  redirect_v_o, redirect_br_v_o, redirect_br_taken_o,
               redirect_br_ntaken_o, redirect_br_nonbr_o, redirect_pc_o,
               redirect_npc_o, redirect_br_metadata_fwd_o,
               attaboy_v_o, attaboy_force_o, attaboy_taken_o, attaboy_ntaken_o,
               attaboy_pc_o, attaboy_br_metadata_fwd_o, drop_cnt_o
    );
endinterface

// File: rtl/bp_be_fe_cmd_gen.sv
// ---------------------------------------------------------------------------
// bp_be_fe_cmd_gen
// Backend-side generator of frontend redirect and branch-training (attaboy)
// commands. Each accepted resolve is compared with the frontend's predicted
// next PC: a mismatch issues a one-cycle registered redirect and parks the
// block in e_drain until the backend signals resume_i; a correct control-flow
// prediction is pushed into a small attaboy FIFO whose head is presented to
// the frontend. Traps always redirect and win over a same-cycle resolve.
//
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   bus        bp_be_fe_cmd_gen_if.master (resolve/trap/resume in,
//              redirect/attaboy/drop_cnt out, attaboy_yumi_i in)
// ---------------------------------------------------------------------------
module bp_be_fe_cmd_gen #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 64,
    parameter int attaboy_els_p               = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    bp_be_fe_cmd_gen_if.master bus
);
    localparam int ptr_w_lp = $clog2(attaboy_els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam int md_w_lp  = branch_metadata_fwd_width_p;

    localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(attaboy_els_p);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp  = ptr_w_lp'(1);

    typedef enum logic [0:0] {
        e_run   = 1'b0,
        e_drain = 1'b1
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    logic w_cf;
    logic w_miss;
    logic w_taken;
    logic w_accept;
    logic w_miss_redirect;
    logic w_redirect;
    logic w_enq;
    logic w_deq;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_av;

    logic                     w_rd_v, w_rd_br_v, w_rd_taken, w_rd_ntaken, w_rd_nonbr;
    logic [vaddr_width_p-1:0] w_rd_pc, w_rd_npc;
    logic [md_w_lp-1:0]       w_rd_md;

    logic                     r_rd_v, r_rd_br_v, r_rd_taken, r_rd_ntaken, r_rd_nonbr;
    logic [vaddr_width_p-1:0] r_rd_pc, r_rd_npc;
    logic [md_w_lp-1:0]       r_rd_md;

    logic [vaddr_width_p-1:0] r_q_pc     [attaboy_els_p];
    logic [md_w_lp-1:0]       r_q_md     [attaboy_els_p];
    logic                     r_q_taken  [attaboy_els_p];
    logic                     r_q_ntaken [attaboy_els_p];
    logic [ptr_w_lp-1:0]      r_rd_ptr;
    logic [ptr_w_lp-1:0]      r_wr_ptr;
    logic [cnt_w_lp-1:0]      r_count;
    logic [7:0]               r_drop_cnt;

    // Resolve classification and queue handshake decode.
    always_comb begin
        w_cf            = bus.resolve_br_i | bus.resolve_jal_i | bus.resolve_jalr_i;
        w_miss          = (bus.resolve_npc_i != bus.resolve_pred_npc_i);
        w_taken         = bus.resolve_taken_i | bus.resolve_jal_i | bus.resolve_jalr_i;
        // A trap in the same cycle discards the resolve entirely.
        w_accept        = bus.resolve_v_i & ~bus.trap_v_i & (r_state == e_run);
        w_miss_redirect = w_accept & w_miss;
        w_redirect      = bus.trap_v_i | w_miss_redirect;
        // Enqueue and redirect are mutually exclusive by construction.
        w_enq           = w_accept & ~w_miss & w_cf;
        w_av            = (r_count != {cnt_w_lp{1'b0}});
        w_deq           = bus.attaboy_yumi_i & w_av;
        w_full          = (r_count == cnt_full_lp);
        // A full queue still accepts when the head leaves in the same cycle.
        w_push          = w_enq & (~w_full | w_deq);
        w_drop          = w_enq & w_full & ~w_deq;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: a trap during drain keeps draining even with resume_i.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            e_run: begin
                if (w_redirect) w_state_nxt = e_drain;
                else            w_state_nxt = e_run;
            end
            e_drain: begin
                if (bus.trap_v_i)      w_state_nxt = e_drain;
                else if (bus.resume_i) w_state_nxt = e_run;
                else                   w_state_nxt = e_drain;
            end
            default: w_state_nxt = e_run;
        endcase
    end

    // FSM output: next-cycle redirect command.
    always_comb begin
        w_rd_v      = 1'b0;
        w_rd_br_v   = 1'b0;
        w_rd_taken  = 1'b0;
        w_rd_ntaken = 1'b0;
        w_rd_nonbr  = 1'b0;
        w_rd_pc     = {vaddr_width_p{1'b0}};
        w_rd_npc    = {vaddr_width_p{1'b0}};
        w_rd_md     = {md_w_lp{1'b0}};
        if (bus.trap_v_i) begin
            w_rd_v   = 1'b1;
            w_rd_pc  = bus.trap_npc_i;
            w_rd_npc = bus.trap_npc_i;
        end else if (w_miss_redirect) begin
            w_rd_v      = 1'b1;
            w_rd_br_v   = 1'b1;
            w_rd_taken  = w_taken;
            w_rd_ntaken = bus.resolve_br_i & ~w_taken;
            w_rd_nonbr  = ~w_cf;
            w_rd_pc     = bus.resolve_tgt_i;
            w_rd_npc    = bus.resolve_npc_i;
            w_rd_md     = bus.resolve_metadata_i;
        end else begin
            w_rd_v = 1'b0;
        end
    end

    // Redirect output registers; asserted for exactly one cycle per request.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_v      <= 1'b0;
            r_rd_br_v   <= 1'b0;
            r_rd_taken  <= 1'b0;
            r_rd_ntaken <= 1'b0;
            r_rd_nonbr  <= 1'b0;
            r_rd_pc     <= {vaddr_width_p{1'b0}};
            r_rd_npc    <= {vaddr_width_p{1'b0}};
            r_rd_md     <= {md_w_lp{1'b0}};
        end else begin
            r_rd_v      <= w_rd_v;
            r_rd_br_v   <= w_rd_br_v;
            r_rd_taken  <= w_rd_taken;
            r_rd_ntaken <= w_rd_ntaken;
            r_rd_nonbr  <= w_rd_nonbr;
            r_rd_pc     <= w_rd_pc;
            r_rd_npc    <= w_rd_npc;
            r_rd_md     <= w_rd_md;
        end
    end

    // Attaboy storage; contents are masked at the outputs while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]     <= bus.resolve_tgt_i;
            r_q_md[r_wr_ptr]     <= bus.resolve_metadata_i;
            r_q_taken[r_wr_ptr]  <= w_taken;
            r_q_ntaken[r_wr_ptr] <= bus.resolve_br_i & ~w_taken;
        end
    end

    // Attaboy pointers and occupancy; a redirect flushes the queue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= {ptr_w_lp{1'b0}};
            r_wr_ptr <= {ptr_w_lp{1'b0}};
            r_count  <= {cnt_w_lp{1'b0}};
        end else if (w_redirect) begin
            r_rd_ptr <= {ptr_w_lp{1'b0}};
            r_wr_ptr <= {ptr_w_lp{1'b0}};
            r_count  <= {cnt_w_lp{1'b0}};
        end else begin
            if (w_deq)  r_rd_ptr <= r_rd_ptr + ptr_one_lp;
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_one_lp;
            case ({w_push, w_deq})
                2'b10:   r_count <= r_count + cnt_one_lp;
                2'b01:   r_count <= r_count - cnt_one_lp;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating drop counter; survives redirects, cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    // Attaboy head presentation, zeroed while the queue is empty.
    always_comb begin
        bus.attaboy_v_o     = w_av;
        bus.attaboy_force_o = w_full;
        if (w_av) begin
            bus.attaboy_pc_o              = r_q_pc[r_rd_ptr];
            bus.attaboy_br_metadata_fwd_o = r_q_md[r_rd_ptr];
            bus.attaboy_taken_o           = r_q_taken[r_rd_ptr];
            bus.attaboy_ntaken_o          = r_q_ntaken[r_rd_ptr];
        end else begin
            bus.attaboy_pc_o              = {vaddr_width_p{1'b0}};
            bus.attaboy_br_metadata_fwd_o = {md_w_lp{1'b0}};
            bus.attaboy_taken_o           = 1'b0;
            bus.attaboy_ntaken_o          = 1'b0;
        end
    end

    assign bus.redirect_v_o               = r_rd_v;
    assign bus.redirect_br_v_o            = r_rd_br_v;
    assign bus.redirect_br_taken_o        = r_rd_taken;
    assign bus.redirect_br_ntaken_o       = r_rd_ntaken;
    assign bus.redirect_br_nonbr_o        = r_rd_nonbr;
    assign bus.redirect_pc_o              = r_rd_pc;
    assign bus.redirect_npc_o             = r_rd_npc;
    assign bus.redirect_br_metadata_fwd_o = r_rd_md;
    assign bus.drop_cnt_o                 = r_drop_cnt;

    bp_be_fe_cmd_gen_chk #(
        .vaddr_width_p(vaddr_width_p)
    ) u_chk (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .resolve_v_i    (bus.resolve_v_i),
        .resolve_pc_i   (bus.resolve_pc_i),
        .attaboy_yumi_i (bus.attaboy_yumi_i),
        .attaboy_v_i    (w_av)
    );
endmodule

// ---------------------------------------------------------------------------
// bp_be_fe_cmd_gen_chk
// Protocol checks on the command generator's environment.
//   attaboy_yumi_i may only be raised while a head entry is presented.
//   A valid resolve must carry a known PC.
// ---------------------------------------------------------------------------
module bp_be_fe_cmd_gen_chk #(
    parameter int vaddr_width_p = 39
) (
    input logic                     clk_i,
    input logic                     reset_n_i,
    input logic                     resolve_v_i,
    input logic [vaddr_width_p-1:0] resolve_pc_i,
    input logic                     attaboy_yumi_i,
    input logic                     attaboy_v_i
);
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) attaboy_yumi_i |-> attaboy_v_i
    );

    a_resolve_pc_known: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) resolve_v_i |-> !$isunknown(resolve_pc_i)
    );
endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_bp_be_fe_cmd_gen
// Directed vector table, hand-written multi-cycle sequences (queue full/drop,
// drop saturation, asynchronous reset) and a randomized run against a
// queue-based reference model of the command generator.
// ---------------------------------------------------------------------------
module tb_bp_be_fe_cmd_gen;
    localparam int VW  = 39;
    localparam int MW  = 64;
    localparam int ELS = 4;

    typedef struct {
        logic          v;
        logic [VW-1:0] pc, tgt, npc, pred;
        logic          br, jal, jalr, tk;
        logic [MW-1:0] md;
        logic          trap;
        logic [VW-1:0] trap_npc;
        logic          resume, yumi;
    } stim_t;

    typedef struct {
        logic          rv, rbr, rtk, rnt, rnb;
        logic [VW-1:0] rpc, rnpc;
        logic [MW-1:0] rmd;
        logic          av, af, atk, ant;
        logic [VW-1:0] apc;
        logic [MW-1:0] amd;
        logic [7:0]    drop;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        logic [VW-1:0] pc;
        logic [MW-1:0] md;
        logic          tk, nt;
    } ab_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    vec_t tbl [16];

    // reference model state
    ab_t m_q[$];
    bit  m_drain;
    int  m_drop;

    always #5 clk = ~clk;

    bp_be_fe_cmd_gen_if #(.vaddr_width_p(VW), .branch_metadata_fwd_width_p(MW)) bus ();

    bp_be_fe_cmd_gen #(
        .vaddr_width_p(VW),
        .branch_metadata_fwd_width_p(MW),
        .attaboy_els_p(ELS)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    function automatic logic [MW-1:0] md_of(input logic [VW-1:0] t);
        md_of = 64'hC0DE_0000_0000_0000 ^ {25'd0, t};
    endfunction

    function automatic stim_t s_idle();
        stim_t s;
        s.v = 1'b0; s.pc = '0; s.tgt = '0; s.npc = '0; s.pred = '0;
        s.br = 1'b0; s.jal = 1'b0; s.jalr = 1'b0; s.tk = 1'b0; s.md = '0;
        s.trap = 1'b0; s.trap_npc = '0; s.resume = 1'b0; s.yumi = 1'b0;
        return s;
    endfunction

    function automatic stim_t s_res(input logic [VW-1:0] tgt, npc, pred,
                                    input logic br, jal, jalr, tk);
        stim_t s = s_idle();
        s.v = 1'b1; s.pc = tgt + 39'h10; s.tgt = tgt; s.npc = npc; s.pred = pred;
        s.br = br; s.jal = jal; s.jalr = jalr; s.tk = tk; s.md = md_of(tgt);
        return s;
    endfunction

    function automatic stim_t with_yumi(input stim_t s);
        stim_t r = s;
        r.yumi = 1'b1;
        return r;
    endfunction

    function automatic stim_t with_resume(input stim_t s);
        stim_t r = s;
        r.resume = 1'b1;
        return r;
    endfunction

    function automatic stim_t with_trap(input stim_t s, input logic [VW-1:0] npc);
        stim_t r = s;
        r.trap = 1'b1; r.trap_npc = npc;
        return r;
    endfunction

    // no redirect; attaboy head as given
    function automatic exp_t e_quiet(input logic av, input logic [VW-1:0] apc,
                                     input logic atk, ant, af, input logic [7:0] drop);
        exp_t e = '{default: '0};
        e.av = av; e.apc = apc; e.amd = av ? md_of(apc) : 64'd0;
        e.atk = atk; e.ant = ant; e.af = af; e.drop = drop;
        return e;
    endfunction

    // redirect issued; queue flushed in the same cycle
    function automatic exp_t e_redir(input logic bv, tk, nt, nb,
                                     input logic [VW-1:0] pc, npc,
                                     input logic [MW-1:0] md, input logic [7:0] drop);
        exp_t e = '{default: '0};
        e.rv = 1'b1; e.rbr = bv; e.rtk = tk; e.rnt = nt; e.rnb = nb;
        e.rpc = pc; e.rnpc = npc; e.rmd = md; e.drop = drop;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        bus.resolve_v_i        = s.v;
        bus.resolve_pc_i       = s.pc;
        bus.resolve_tgt_i      = s.tgt;
        bus.resolve_npc_i      = s.npc;
        bus.resolve_pred_npc_i = s.pred;
        bus.resolve_br_i       = s.br;
        bus.resolve_jal_i      = s.jal;
        bus.resolve_jalr_i     = s.jalr;
        bus.resolve_taken_i    = s.tk;
        bus.resolve_metadata_i = s.md;
        bus.trap_v_i           = s.trap;
        bus.trap_npc_i         = s.trap_npc;
        bus.resume_i           = s.resume;
        bus.attaboy_yumi_i     = s.yumi;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".redirect_v"},      64'(bus.redirect_v_o),               64'(e.rv));
        chk({tag, ".redirect_br_v"},   64'(bus.redirect_br_v_o),            64'(e.rbr));
        chk({tag, ".redirect_taken"},  64'(bus.redirect_br_taken_o),        64'(e.rtk));
        chk({tag, ".redirect_ntaken"}, 64'(bus.redirect_br_ntaken_o),       64'(e.rnt));
        chk({tag, ".redirect_nonbr"},  64'(bus.redirect_br_nonbr_o),        64'(e.rnb));
        chk({tag, ".redirect_pc"},     64'(bus.redirect_pc_o),              64'(e.rpc));
        chk({tag, ".redirect_npc"},    64'(bus.redirect_npc_o),             64'(e.rnpc));
        chk({tag, ".redirect_md"},     64'(bus.redirect_br_metadata_fwd_o), 64'(e.rmd));
        chk({tag, ".attaboy_v"},       64'(bus.attaboy_v_o),                64'(e.av));
        chk({tag, ".attaboy_force"},   64'(bus.attaboy_force_o),            64'(e.af));
        chk({tag, ".attaboy_taken"},   64'(bus.attaboy_taken_o),            64'(e.atk));
        chk({tag, ".attaboy_ntaken"},  64'(bus.attaboy_ntaken_o),           64'(e.ant));
        chk({tag, ".attaboy_pc"},      64'(bus.attaboy_pc_o),               64'(e.apc));
        chk({tag, ".attaboy_md"},      64'(bus.attaboy_br_metadata_fwd_o),  64'(e.amd));
        chk({tag, ".drop_cnt"},        64'(bus.drop_cnt_o),                 64'(e.drop));
    endtask

    // Behavioural model: one call per clock, returns the outputs expected after the edge.
    task automatic model_step(input stim_t s, output exp_t e);
        logic cf, tk, redir, enq, popped, full;
        ab_t  a;
        e      = '{default: '0};
        cf     = s.br | s.jal | s.jalr;
        tk     = s.tk | s.jal | s.jalr;
        redir  = 1'b0;
        enq    = 1'b0;
        popped = 1'b0;
        if (s.trap) begin
            redir = 1'b1; e.rv = 1'b1; e.rpc = s.trap_npc; e.rnpc = s.trap_npc;
            m_drain = 1'b1;
        end else if (!m_drain && s.v) begin
            if (s.npc != s.pred) begin
                redir = 1'b1; e.rv = 1'b1; e.rbr = 1'b1; e.rtk = tk;
                e.rnt = s.br & ~tk; e.rnb = ~cf;
                e.rpc = s.tgt; e.rnpc = s.npc; e.rmd = s.md;
                m_drain = 1'b1;
            end else if (cf) begin
                enq = 1'b1;
                a.pc = s.tgt; a.md = s.md; a.tk = tk; a.nt = s.br & ~tk;
            end
        end else if (m_drain && s.resume) begin
            m_drain = 1'b0;
        end
        if (redir) begin
            m_q.delete();
        end else begin
            full = (m_q.size() == ELS);
            if (s.yumi && m_q.size() > 0) begin
                void'(m_q.pop_front());
                popped = 1'b1;
            end
            if (enq) begin
                if (!full || popped) m_q.push_back(a);
                else if (m_drop < 255) m_drop++;
            end
        end
        e.av   = (m_q.size() > 0);
        e.af   = (m_q.size() == ELS);
        e.drop = 8'(m_drop);
        if (e.av) begin
            e.apc = m_q[0].pc; e.amd = m_q[0].md; e.atk = m_q[0].tk; e.ant = m_q[0].nt;
        end
    endtask

    initial begin
        stim_t s;
        exp_t  e;

        // ---- directed vector table (starts from reset: e_run, queue empty) ----
        tbl[0]  = '{s_res(39'h1000, 39'h1000, 39'h1000, 1'b1, 1'b0, 1'b0, 1'b1),
                    e_quiet(1'b1, 39'h1000, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[1]  = '{with_yumi(s_idle()), e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0)};
        tbl[2]  = '{s_res(39'h2000, 39'h1008, 39'h1008, 1'b1, 1'b0, 1'b0, 1'b0),
                    e_quiet(1'b1, 39'h2000, 1'b0, 1'b1, 1'b0, 8'd0)};
        tbl[3]  = '{s_res(39'h3000, 39'h3000, 39'h3000, 1'b0, 1'b1, 1'b0, 1'b0),
                    e_quiet(1'b1, 39'h2000, 1'b0, 1'b1, 1'b0, 8'd0)};
        tbl[4]  = '{s_res(39'h4000, 39'h4004, 39'h5000, 1'b0, 1'b0, 1'b0, 1'b0),
                    e_redir(1'b1, 1'b0, 1'b0, 1'b1, 39'h4000, 39'h4004, md_of(39'h4000), 8'd0)};
        tbl[5]  = '{s_idle(), e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0)};
        tbl[6]  = '{s_res(39'h4100, 39'h4100, 39'h4100, 1'b1, 1'b0, 1'b0, 1'b1),
                    e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0)};
        tbl[7]  = '{with_resume(s_res(39'h6000, 39'h6000, 39'h6000, 1'b1, 1'b0, 1'b0, 1'b1)),
                    e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0)};
        tbl[8]  = '{s_res(39'h7000, 39'h7000, 39'h7000, 1'b1, 1'b0, 1'b0, 1'b1),
                    e_quiet(1'b1, 39'h7000, 1'b1, 1'b0, 1'b0, 8'd0)};
        tbl[9]  = '{s_res(39'h1100, 39'h1004, 39'h2000, 1'b1, 1'b0, 1'b0, 1'b0),
                    e_redir(1'b1, 1'b0, 1'b1, 1'b0, 39'h1100, 39'h1004, md_of(39'h1100), 8'd0)};
        tbl[10] = '{with_trap(s_idle(), 39'h9000),
                    e_redir(1'b0, 1'b0, 1'b0, 1'b0, 39'h9000, 39'h9000, 64'd0, 8'd0)};
        tbl[11] = '{with_resume(s_idle()), e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0)};
        tbl[12] = '{with_trap(s_res(39'h1200, 39'h1004, 39'h2000, 1'b1, 1'b0, 1'b0, 1'b0), 39'h8000_0000),
                    e_redir(1'b0, 1'b0, 1'b0, 1'b0, 39'h8000_0000, 39'h8000_0000, 64'd0, 8'd0)};
        tbl[13] = '{with_resume(s_idle()), e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0)};
        tbl[14] = '{s_res(39'hA000, 39'hA000, 39'hB000, 1'b0, 1'b0, 1'b1, 1'b0),
                    e_redir(1'b1, 1'b1, 1'b0, 1'b0, 39'hA000, 39'hA000, md_of(39'hA000), 8'd0)};
        tbl[15] = '{with_resume(s_idle()), e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0)};

        // ---- reset state ----
        rst_n = 1'b0;
        drive(s_idle());
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].s);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].e);
        end

        // ---- fill to full, drop, accept-with-yumi at full ----
        for (int k = 1; k <= 4; k++) begin
            drive(s_res(39'(k * 256), 39'(k * 256), 39'(k * 256), 1'b1, 1'b0, 1'b0, 1'b1));
            tick();
            check_out($sformatf("fill%0d", k),
                      e_quiet(1'b1, 39'h100, 1'b1, 1'b0, (k == 4), 8'd0));
        end
        drive(s_res(39'h500, 39'h500, 39'h500, 1'b1, 1'b0, 1'b0, 1'b1));
        tick();
        check_out("full_drop", e_quiet(1'b1, 39'h100, 1'b1, 1'b0, 1'b1, 8'd1));
        drive(with_yumi(s_res(39'h600, 39'h600, 39'h600, 1'b1, 1'b0, 1'b0, 1'b1)));
        tick();
        check_out("full_yumi", e_quiet(1'b1, 39'h200, 1'b1, 1'b0, 1'b1, 8'd1));
        drive(with_yumi(s_idle()));
        tick();
        check_out("pop1", e_quiet(1'b1, 39'h300, 1'b1, 1'b0, 1'b0, 8'd1));
        tick();
        check_out("pop2", e_quiet(1'b1, 39'h400, 1'b1, 1'b0, 1'b0, 8'd1));
        tick();
        check_out("pop3", e_quiet(1'b1, 39'h600, 1'b1, 1'b0, 1'b0, 8'd1));
        tick();
        check_out("pop4", e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd1));

        // ---- 4 fills then 300 drops: counter saturates ----
        drive(s_res(39'h800, 39'h800, 39'h800, 1'b1, 1'b0, 1'b0, 1'b0));
        repeat (304) tick();
        check_out("drop_sat", e_quiet(1'b1, 39'h800, 1'b0, 1'b1, 1'b1, 8'd255));

        // ---- asynchronous reset with a full queue ----
        drive(s_idle());
        #2 rst_n = 1'b0;
        #1 check_out("arst_full", e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0));
        tick();
        rst_n = 1'b1;

        // ---- asynchronous reset while a redirect is in flight (drain) ----
        drive(s_res(39'hC00, 39'hC04, 39'hD00, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        check_out("pre_arst", e_redir(1'b1, 1'b0, 1'b1, 1'b0, 39'hC00, 39'hC04, md_of(39'hC00), 8'd0));
        drive(s_idle());
        #2 rst_n = 1'b0;
        #1 check_out("arst_drain", e_quiet(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 8'd0));
        tick();
        rst_n = 1'b1;
        drive(s_res(39'hE00, 39'hE00, 39'hE00, 1'b1, 1'b0, 1'b0, 1'b1));
        tick();
        check_out("post_arst", e_quiet(1'b1, 39'hE00, 1'b1, 1'b0, 1'b0, 8'd0));

        // ---- randomized run against the reference model ----
        drive(s_idle());
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_q.delete();
        m_drain = 1'b0;
        m_drop  = 0;
        for (int c = 0; c < 3000; c++) begin
            int sel;
            int yrate;
            s        = s_idle();
            s.v      = ($urandom_range(0, 9) < 7);
            sel      = $urandom_range(0, 3);
            s.br     = (sel == 1);
            s.jal    = (sel == 2);
            s.jalr   = (sel == 3);
            s.tk     = 1'($urandom_range(0, 1));
            s.npc    = 39'({$urandom, $urandom});
            s.tgt    = 39'({$urandom, $urandom});
            s.pc     = 39'({$urandom, $urandom});
            s.pred   = ($urandom_range(0, 9) < 2) ? (s.npc ^ 39'h40) : s.npc;
            s.md     = {$urandom, $urandom};
            s.trap   = ($urandom_range(0, 29) == 0);
            s.trap_npc = 39'({$urandom, $urandom});
            s.resume = ($urandom_range(0, 4) == 0);
            yrate    = ((c / 500) % 2 == 1) ? 1 : 6;
            s.yumi   = (m_q.size() > 0) && ($urandom_range(0, 9) < yrate);
            drive(s);
            model_step(s, e);
            tick();
            check_out($sformatf("rand%0d", c), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
